// File: rtl/iadc_pkg.sv
// ----------------------------------------------------------------------------
// iadc_pkg
// Shared definitions for the incremental ADC conversion sequencer.
//   conv_state_t : sequencer states (IDLE, RESET, CONVERT, WAIT, CAPTURE)
//   IADC_*       : default conversion parameters used by the sequencer and
//                  its result buffer
// ----------------------------------------------------------------------------
package iadc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET,
      ST_CONVERT,
      ST_WAIT,
      ST_CAPTURE
   } conv_state_t;

   localparam int IADC_OSR     = 512;
   localparam int IADC_DATA_W  = 12;
   localparam int IADC_RST_CYC = 2;
   localparam int IADC_TIMEOUT = 16;

endpackage

// File: rtl/iadc_result_buf.sv
// ----------------------------------------------------------------------------
// iadc_result_buf
// One-entry valid/ready holding register for finished conversion results.
// A write that arrives while an unread value is held (and not being drained
// in the same cycle) is dropped and flagged through the sticky overrun bit.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   wr_en/wr_data : result offered by the sequencer (one-cycle strobe)
//   clr_flags     : clears the sticky overrun flag
//   result_ready  : downstream accepts the held value
//   result        : held value, stable while result_valid is high
//   result_valid  : result holds an unread value
//   overrun       : sticky, a result was dropped
// ----------------------------------------------------------------------------
module iadc_result_buf
   import iadc_pkg::*;
#(
   parameter int DATA_W = IADC_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_flags,
   input  logic              result_ready,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic              overrun
);

   logic drain;

   assign drain = result_valid & result_ready;

   // The holding register accepts a new value when it is empty or when the
   // current value is being taken this very cycle, so back-to-back results
   // with a ready consumer never lose data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result       <= '0;
         result_valid <= 1'b0;
      end else if (wr_en && (!result_valid || drain)) begin
         result       <= wr_data;
         result_valid <= 1'b1;
      end else if (drain) begin
         result_valid <= 1'b0;
      end
   end

   // Overrun stays set until the sequencer starts a fresh run from idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun <= 1'b0;
      end else if (clr_flags) begin
         overrun <= 1'b0;
      end else if (wr_en && result_valid && !result_ready) begin
         overrun <= 1'b1;
      end
   end

endmodule

// File: rtl/iadc_conv_ctrl.sv
// ----------------------------------------------------------------------------
// iadc_conv_ctrl
// Conversion sequencer for the incremental ADC. Each conversion resets the
// modulator and decimation filter, enables the modulator for exactly OSR
// clocks, then waits for the filter's new_data edge and captures its result
// into a one-entry valid/ready buffer.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : single-cycle request, honoured only when idle
//   continuous          : restart automatically after each conversion
//   abort               : cancel a conversion in RESET/CONVERT/WAIT
//   filt_data           : filter data_out
//   filt_new_data       : filter new_data (rising edge marks a result)
//   filt_rst_n          : filter reset, active-low
//   mod_rst             : modulator integrator reset, active-high
//   mod_en              : modulator sample enable
//   result/result_valid : captured value and its valid flag
//   result_ready        : downstream accepts result
//   busy                : sequencer not idle
//   overrun             : sticky, a result was dropped
//   timeout_err         : sticky, new_data never arrived
// ----------------------------------------------------------------------------
module iadc_conv_ctrl
   import iadc_pkg::*;
#(
   parameter int OSR     = IADC_OSR,
   parameter int DATA_W  = IADC_DATA_W,
   parameter int RST_CYC = IADC_RST_CYC,
   parameter int TIMEOUT = IADC_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              continuous,
   input  logic              abort,
   input  logic [DATA_W-1:0] filt_data,
   input  logic              filt_new_data,
   output logic              filt_rst_n,
   output logic              mod_rst,
   output logic              mod_en,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   input  logic              result_ready,
   output logic              busy,
   output logic              overrun,
   output logic              timeout_err
);

   localparam int CNT_MAX = (OSR > TIMEOUT) ? ((OSR > RST_CYC) ? OSR : RST_CYC)
                                            : ((TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
   localparam logic [CNT_W-1:0] OSR_LAST = CNT_W'(OSR - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   conv_state_t       state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              new_data_q;
   logic              nd_rise;
   logic              rise_pend;
   logic [DATA_W-1:0] cap_data;
   logic              cap_wr;
   logic              clr_flags;
   logic              to_set;

   assign nd_rise = filt_new_data & ~new_data_q;

   // Next-state logic. One shared counter times the reset hold, the OSR
   // sample window and the new_data timeout, since only one of them is ever
   // running. Abort is checked first so it overrides every other exit.
   // A new_data edge seen before the sample window closes is remembered in
   // rise_pend so the modulator still gets its full OSR samples.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cap_wr    = 1'b0;
      clr_flags = 1'b0;
      to_set    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_RESET;
               cnt_nxt   = '0;
               clr_flags = 1'b1;
            end
         end
         ST_RESET: begin
            if (abort) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else if (cnt == RST_LAST) begin
               state_nxt = ST_CONVERT;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_CONVERT: begin
            if (abort) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else if (cnt == OSR_LAST) begin
               state_nxt = ST_WAIT;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (abort) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else if (nd_rise || rise_pend) begin
               state_nxt = ST_CAPTURE;
               cnt_nxt   = '0;
            end else if (cnt == TMO_LAST) begin
               to_set    = 1'b1;
               state_nxt = continuous ? ST_RESET : ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_CAPTURE: begin
            cap_wr    = 1'b1;
            state_nxt = continuous ? ST_RESET : ST_IDLE;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State, counter and new_data edge tracking. The filter value is latched
   // in the edge cycle so CAPTURE writes exactly what the filter presented
   // alongside its strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         new_data_q <= 1'b0;
         rise_pend  <= 1'b0;
         cap_data   <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         new_data_q <= filt_new_data;
         if (state == ST_CONVERT && nd_rise) begin
            rise_pend <= 1'b1;
         end else if (state != ST_CONVERT && state != ST_WAIT) begin
            rise_pend <= 1'b0;
         end
         if (nd_rise && (state == ST_CONVERT || state == ST_WAIT)) begin
            cap_data <= filt_data;
         end
      end
   end

   // Control outputs are registered from the next state so they change in
   // the same cycle as the state itself and never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_rst_n <= 1'b0;
         mod_rst    <= 1'b1;
         mod_en     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         filt_rst_n <= !(state_nxt inside {ST_IDLE, ST_RESET});
         mod_rst    <= (state_nxt inside {ST_IDLE, ST_RESET});
         mod_en     <= (state_nxt == ST_CONVERT);
         busy       <= (state_nxt != ST_IDLE);
      end
   end

   // Timeout flag is sticky until the next start from idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_err <= 1'b0;
      end else if (clr_flags) begin
         timeout_err <= 1'b0;
      end else if (to_set) begin
         timeout_err <= 1'b1;
      end
   end

   iadc_result_buf #(
      .DATA_W (DATA_W)
   ) u_result_buf (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (cap_wr),
      .wr_data      (cap_data),
      .clr_flags    (clr_flags),
      .result_ready (result_ready),
      .result       (result),
      .result_valid (result_valid),
      .overrun      (overrun)
   );

endmodule
